// File: rtl/i2s_tdm_tx.sv
// Multi-channel I2S / left-justified TDM serialiser with SCLK/LRCLK derived from CLK.
// Accepts one frame per audio period; underruns send zeros or repeat the last frame.
module i2s_tdm_tx #(
  parameter int DATA_W        = 24,
  parameter int SLOT_W        = 32,
  parameter int CHANNELS      = 2,
  parameter int SCLK_DIV      = 4,
  parameter int JUSTIFY       = 0,
  parameter int UNDERRUN_HOLD = 0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       EN,
  input  logic [CHANNELS*DATA_W-1:0] AUDIO_IN,
  input  logic                       AUDIO_VALID,
  output logic                       AUDIO_READY,
  output logic                       SCLK,
  output logic                       LRCLK,
  output logic                       DOUT,
  output logic                       FRAME_START,
  output logic                       UNDERRUN,
  output logic [15:0]                UNDERRUN_CNT,
  input  logic                       CLR_UNDERRUN
);

  localparam int FRAME_W = CHANNELS * SLOT_W;
  localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int MSB_OFF = (JUSTIFY != 0) ? 0 : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(SCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(FRAME_W / 2);

  logic [DIV_W-1:0]           div_q, div_d;
  logic [BIT_W-1:0]           bit_q, bit_d;
  logic [FRAME_W-1:0]         frame_q, frame_d;
  logic [CHANNELS*DATA_W-1:0] last_q, last_d;
  logic                       run_q;
  logic                       urun_q, urun_d;
  logic [15:0]                ucnt_q, ucnt_d;

  logic                       load;
  logic                       active;
  logic [CHANNELS*DATA_W-1:0] src;
  logic [FRAME_W-1:0]         packed_frame;

  assign load = EN & ~RESET & (div_q == DIV_LAST) & (bit_q == BIT_LAST);
  assign src  = AUDIO_VALID ? AUDIO_IN : ((UNDERRUN_HOLD != 0) ? last_q : '0);

  // Each slot is transmitted MSB first from the top of the shift register.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_pack
      assign packed_frame[FRAME_W-1-gi*SLOT_W -: SLOT_W] =
        SLOT_W'(src[gi*DATA_W +: DATA_W]) << (SLOT_W - DATA_W - MSB_OFF);
    end
  endgenerate

  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    last_d  = last_q;
    urun_d  = urun_q;
    ucnt_d  = ucnt_q;
    if (!EN) begin
      div_d   = DIV_LAST;
      bit_d   = BIT_LAST;
      frame_d = '0;
      last_d  = '0;
    end else begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      if (div_q == DIV_LAST) begin
        bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
        frame_d = load ? packed_frame : {frame_q[FRAME_W-2:0], 1'b0};
      end
      if (load && AUDIO_VALID) last_d = AUDIO_IN;
    end
    // A simultaneous clear loses to a fresh underrun.
    if (load && !AUDIO_VALID) begin
      urun_d = 1'b1;
      if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 1'b1;
    end else if (CLR_UNDERRUN) begin
      urun_d = 1'b0;
      ucnt_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_q   <= DIV_LAST;
      bit_q   <= BIT_LAST;
      frame_q <= '0;
      last_q  <= '0;
      run_q   <= 1'b0;
      urun_q  <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      last_q  <= last_d;
      run_q   <= EN;
      urun_q  <= urun_d;
      ucnt_q  <= ucnt_d;
    end
  end

  // run_q keeps the bus quiet during the very first load cycle after enable.
  assign active       = EN & run_q;
  assign AUDIO_READY  = load;
  assign SCLK         = active & (div_q >= DIV_HALF);
  assign LRCLK        = active & (bit_q >= BIT_RIGHT);
  assign DOUT         = active & frame_q[FRAME_W-1];
  assign FRAME_START  = EN & (bit_q == '0) & (div_q == '0);
  assign UNDERRUN     = urun_q;
  assign UNDERRUN_CNT = ucnt_q;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Bench for i2s_tdm_tx: three instances (I2S/zero-fill, left-justified/hold, 4-channel I2S)
// checked by a frame scoreboard plus directed underrun/enable/reset checks.
module tb_i2s_tdm_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en01, en2, val01, val2, clr;
  logic [31:0] a01;
  logic [63:0] a2;
  logic [2:0]  rdy, sclk, lr, dout, fs, ur;
  logic [15:0] ucnt0, ucnt1, ucnt2;

  i2s_tdm_tx #(.DATA_W(16), .SLOT_W(32), .CHANNELS(2), .SCLK_DIV(4), .JUSTIFY(0), .UNDERRUN_HOLD(0)) dut0 (
    .CLK(clk), .RESET(rst), .EN(en01), .AUDIO_IN(a01), .AUDIO_VALID(val01), .AUDIO_READY(rdy[0]),
    .SCLK(sclk[0]), .LRCLK(lr[0]), .DOUT(dout[0]), .FRAME_START(fs[0]), .UNDERRUN(ur[0]),
    .UNDERRUN_CNT(ucnt0), .CLR_UNDERRUN(clr));

  i2s_tdm_tx #(.DATA_W(16), .SLOT_W(32), .CHANNELS(2), .SCLK_DIV(4), .JUSTIFY(1), .UNDERRUN_HOLD(1)) dut1 (
    .CLK(clk), .RESET(rst), .EN(en01), .AUDIO_IN(a01), .AUDIO_VALID(val01), .AUDIO_READY(rdy[1]),
    .SCLK(sclk[1]), .LRCLK(lr[1]), .DOUT(dout[1]), .FRAME_START(fs[1]), .UNDERRUN(ur[1]),
    .UNDERRUN_CNT(ucnt1), .CLR_UNDERRUN(clr));

  i2s_tdm_tx #(.DATA_W(16), .SLOT_W(32), .CHANNELS(4), .SCLK_DIV(4), .JUSTIFY(0), .UNDERRUN_HOLD(0)) dut2 (
    .CLK(clk), .RESET(rst), .EN(en2), .AUDIO_IN(a2), .AUDIO_VALID(val2), .AUDIO_READY(rdy[2]),
    .SCLK(sclk[2]), .LRCLK(lr[2]), .DOUT(dout[2]), .FRAME_START(fs[2]), .UNDERRUN(ur[2]),
    .UNDERRUN_CNT(ucnt2), .CLR_UNDERRUN(clr));

  int tests = 0;
  int fails = 0;

  int           phase [3];
  int           idx [3];
  logic [127:0] cap_d [3];
  logic [127:0] cap_l [3];
  logic         stable_ok [3];
  logic         prev_sclk [3];
  logic         prev_dout [3];
  logic [63:0]  mlast [3];
  logic [127:0] q0[$], q1[$], q2[$];

  function automatic int nch(input int i);
    return (i == 2) ? 4 : 2;
  endfunction

  function automatic int flen(input int i);
    return nch(i) * 32 * 4;
  endfunction

  function automatic bit is_lj(input int i);
    return i == 1;
  endfunction

  // Serial stream index k = slot*32 + slot bit; sample MSB at slot bit 1 (I2S) or 0 (LJ).
  function automatic logic [127:0] expbits(input logic [63:0] s, input int n, input bit lj);
    logic [127:0] v = '0;
    for (int c = 0; c < n; c++)
      for (int b = 0; b < 16; b++)
        v[c*32 + (lj ? 0 : 1) + b] = s[c*16 + 15 - b];
    return v;
  endfunction

  function automatic logic [127:0] explr(input int n);
    logic [127:0] v = '0;
    for (int k = 0; k < n*32; k++) v[k] = (k >= n*16);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input int i, input logic [127:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic sb_clear(input int i);
    case (i)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  function automatic int sb_size(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic sb_pop(input int i, output logic [127:0] v);
    case (i)
      0: v = q0.pop_front();
      1: v = q1.pop_front();
      default: v = q2.pop_front();
    endcase
  endtask

  task automatic step();
    logic e, v, exp_load, exp_fs;
    logic [63:0] a, frame;
    logic [127:0] ev;
    #1;
    for (int i = 0; i < 3; i++) begin
      e = (i == 2) ? en2 : en01;
      v = (i == 2) ? val2 : val01;
      a = (i == 2) ? a2 : {32'h0, a01};
      if (!rst && e) begin
        exp_load = (phase[i] == 0);
        if (rdy[i] || exp_load) chk($sformatf("ready%0d", i), rdy[i], exp_load);
        if (exp_load) begin
          if (v) begin
            frame = a;
            mlast[i] = a;
          end else begin
            frame = is_lj(i) ? mlast[i] : 64'h0;
          end
          sb_push(i, expbits(frame, nch(i), is_lj(i)));
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      e = (i == 2) ? en2 : en01;
      if (rst || !e) begin
        phase[i] = 0;
        idx[i] = -1;
        mlast[i] = '0;
        sb_clear(i);
      end else begin
        phase[i] = (phase[i] + 1) % flen(i);
        exp_fs = (phase[i] == 1);
        if (fs[i] || exp_fs) chk($sformatf("frame_start%0d", i), fs[i], exp_fs);
        if (fs[i]) begin
          idx[i] = 0;
          cap_d[i] = '0;
          cap_l[i] = '0;
          stable_ok[i] = 1'b1;
        end else if (idx[i] >= 0 && sclk[i] && !prev_sclk[i]) begin
          cap_d[i][idx[i]] = dout[i];
          cap_l[i][idx[i]] = lr[i];
          if (dout[i] !== prev_dout[i]) stable_ok[i] = 1'b0;
          idx[i]++;
          if (idx[i] == nch(i) * 32) begin
            chk($sformatf("sb_has%0d", i), sb_size(i) != 0, 1);
            if (sb_size(i) != 0) begin
              sb_pop(i, ev);
              chk($sformatf("dout_frame%0d", i), cap_d[i], ev);
              chk($sformatf("lrclk_frame%0d", i), cap_l[i], explr(nch(i)));
              chk($sformatf("dout_stable%0d", i), stable_ok[i], 1);
            end
            idx[i] = -1;
          end
        end
      end
      prev_sclk[i] = sclk[i];
      prev_dout[i] = dout[i];
    end
  endtask

  task automatic step_to_load();
    for (int k = 0; k < 2000 && phase[0] != 0; k++) step();
  endtask

  task automatic do_frame(input logic [31:0] d, input logic v);
    step_to_load();
    a01 = d;
    val01 = v;
    step();
  endtask

  initial begin
    rst = 1'b1; en01 = 1'b0; en2 = 1'b0; val01 = 1'b0; val2 = 1'b0; clr = 1'b0;
    a01 = '0; a2 = '0;
    for (int i = 0; i < 3; i++) begin
      phase[i] = 0; idx[i] = -1; mlast[i] = '0; cap_d[i] = '0; cap_l[i] = '0;
      stable_ok[i] = 1'b1; prev_sclk[i] = 1'b0; prev_dout[i] = 1'b0;
    end

    // Reset and idle
    repeat (3) step();
    chk("rst_outputs", {rdy, sclk, lr, dout, fs, ur}, 0);
    chk("rst_counts", {ucnt0, ucnt1, ucnt2}, 0);
    rst = 1'b0;
    repeat (4) step();
    chk("idle_outputs", {rdy, sclk, lr, dout, fs, ur}, 0);

    // Normal frames in both justifications
    a01 = 32'h7FFE_8001; val01 = 1'b1; en01 = 1'b1;
    #1 chk("first_en_ready", rdy[1:0], 2'b11);
    step();
    do_frame(32'h1234_ABCD, 1'b1);
    do_frame(32'hA5C3_0F0F, 1'b1);

    // Underruns: zero fill on dut0, repeat on dut1
    do_frame(32'hDEAD_BEEF, 1'b0);
    chk("ur_flag1", {ur[1], ur[0]}, 2'b11);
    chk("ur_cnt1", {ucnt1, ucnt0}, {16'd1, 16'd1});
    do_frame(32'h0, 1'b0);
    do_frame(32'h0, 1'b0);
    chk("ur_cnt3", {ucnt1, ucnt0}, {16'd3, 16'd3});
    do_frame(32'h0001_8000, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ur_clear", {ur[1:0], ucnt1, ucnt0}, 0);
    step_to_load();
    clr = 1'b1; val01 = 1'b0;
    step();
    clr = 1'b0; val01 = 1'b1; a01 = 32'h5555_AAAA;
    chk("ur_clr_collide", {ur[1:0], ucnt1, ucnt0}, {2'b11, 16'd1, 16'd1});

    // Four-channel instance
    a2 = {16'h0004, 16'h0003, 16'h0002, 16'h0001}; val2 = 1'b1; en2 = 1'b1;
    step();
    a2 = 64'h8000_7FFF_0001_FFFF;
    repeat (1100) step();

    // Drop EN at bit 20, then re-enable
    step_to_load();
    step();
    repeat (80) step();
    en01 = 1'b0;
    step();
    chk("en_drop_outputs", {rdy[1:0], sclk[1:0], lr[1:0], dout[1:0], fs[1:0]}, 0);
    chk("en_drop_cnt", {ucnt1, ucnt0}, {16'd1, 16'd1});
    repeat (5) step();
    a01 = 32'h0F0F_F0F0; en01 = 1'b1;
    #1 chk("reen_ready", rdy[1:0], 2'b11);
    repeat (600) step();

    // Asynchronous reset mid-frame
    rst = 1'b1;
    #1 chk("async_rst_outputs", {rdy, sclk, lr, dout, fs, ur}, 0);
    chk("async_rst_counts", {ucnt0, ucnt1, ucnt2}, 0);
    step();
    step();
    rst = 1'b0;
    repeat (600) step();

    for (int i = 0; i < 3; i++) chk($sformatf("sb_drain%0d", i), sb_size(i) <= 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
